// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module   : multicycle_ctrl_if
// Brief    : Handshake/strobe bundle between the multicycle controller and datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel_data;
  logic        ir_write;
  logic        mdr_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  mem_to_reg;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        trap;
  logic        instr_retired;
  logic [2:0]  state;
  logic [31:0] instret;

  modport master (
    input  opcode, branch_taken, mem_ready,
    output mem_req, mem_we, mem_sel_data, ir_write, mdr_write, pc_write, pc_src,
           reg_write, mem_to_reg, alu_src, alu_op, trap, instr_retired, state, instret
  );

  modport slave (
    output opcode, branch_taken, mem_ready,
    input  mem_req, mem_we, mem_sel_data, ir_write, mdr_write, pc_write, pc_src,
           reg_write, mem_to_reg, alu_src, alu_op, trap, instr_retired, state, instret
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multicycle RV32I control FSM with memory-wait timeout and retire counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] instret_q, instret_d;
  logic        req;
  logic        retire;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR) ||
           (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    req               = 1'b0;
    retire            = 1'b0;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_sel_data  = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mdr_write     = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_src        = 2'b00;
    bus.reg_write     = 1'b0;
    bus.mem_to_reg    = 2'b00;
    bus.alu_src       = 1'b0;
    bus.alu_op        = 2'b00;
    bus.trap          = 1'b0;

    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          state_d      = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        op_d    = bus.opcode;
        state_d = is_legal(bus.opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        bus.alu_src = !((op_q == OP_R) || (op_q == OP_BRANCH));
        if ((op_q == OP_R) || (op_q == OP_I))
          bus.alu_op = 2'b10;
        else if (op_q == OP_BRANCH)
          bus.alu_op = 2'b01;
        if (op_q == OP_BRANCH) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = bus.branch_taken ? 2'b01 : 2'b00;
          retire       = 1'b1;
          state_d      = S_FETCH;
        end else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        req              = 1'b1;
        bus.mem_sel_data = 1'b1;
        bus.mem_we       = (op_q == OP_STORE);
        if (bus.mem_ready) begin
          if (op_q == OP_STORE) begin
            bus.pc_write = 1'b1;
            retire       = 1'b1;
            state_d      = S_FETCH;
          end else begin
            bus.mdr_write = 1'b1;
            state_d       = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        bus.pc_write  = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
        if (op_q == OP_LOAD)
          bus.mem_to_reg = 2'b01;
        else if ((op_q == OP_JAL) || (op_q == OP_JALR))
          bus.mem_to_reg = 2'b10;
        if (op_q == OP_JAL)
          bus.pc_src = 2'b10;
        else if (op_q == OP_JALR)
          bus.pc_src = 2'b11;
      end
      S_TRAP: begin
        bus.trap = 1'b1;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase

    // Any state change (entry to FETCH or MEM included) restarts the wait count.
    if (state_d != state_q)
      wait_d = 8'd0;
    else if (req && !bus.mem_ready)
      wait_d = wait_q + 8'd1;
    else
      wait_d = wait_q;

    bus.mem_req       = req;
    bus.instr_retired = retire;
    instret_d         = instret_q + {31'd0, retire};

    if (!rst_n) begin
      bus.mem_req       = 1'b0;
      bus.mem_we        = 1'b0;
      bus.mem_sel_data  = 1'b0;
      bus.ir_write      = 1'b0;
      bus.mdr_write     = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_src        = 2'b00;
      bus.reg_write     = 1'b0;
      bus.mem_to_reg    = 2'b00;
      bus.alu_src       = 1'b0;
      bus.alu_op        = 2'b00;
      bus.trap          = 1'b0;
      bus.instr_retired = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= 7'd0;
      wait_q    <= 8'd0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.instret = instret_q;

endmodule

`default_nettype wire
